// File: rtl/pwm_counter_if.sv
// ============================================================================
// Module : pwm_counter_if
// Counter configuration inputs and timebase outputs shared with pwm_gen.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pwm_counter_if #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
);
  logic             en;
  logic             count_reset;
  logic [WIDTH-1:0] period;
  logic [PSC_W-1:0] prescale;
  logic             upnotdown;
  logic [WIDTH-1:0] count_val;
  logic             ovf;
  logic             udf;

  modport master (
    output en, count_reset, period, prescale, upnotdown,
    input  count_val, ovf, udf
  );

  modport slave (
    input  en, count_reset, period, prescale, upnotdown,
    output count_val, ovf, udf
  );
endinterface

`default_nettype wire

// File: rtl/pwm_counter.sv
// ============================================================================
// Module : pwm_counter
// Prescaled up/down timebase counter with single-cycle wrap pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pwm_counter #(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  pwm_counter_if.slave   bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q,   psc_d;
  logic             ovf_q,   ovf_d;
  logic             udf_q,   udf_d;
  logic             tick;

  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    tick    = 1'b0;
    if (bus.count_reset) begin
      count_d = '0;
      psc_d   = '0;
    end else if (!bus.en) begin
      psc_d   = '0;
    end else begin
      // >= lets a lowered prescale take effect without a full wrap
      tick  = (psc_q >= bus.prescale);
      psc_d = tick ? '0 : psc_q + 1'b1;
      if (tick) begin
        if (bus.upnotdown) begin
          if (count_q >= bus.period) begin
            count_d = '0;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            count_d = bus.period;
            udf_d   = 1'b1;
          end else if (count_q > bus.period) begin
            count_d = bus.period;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      psc_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.count_val = count_q;
  assign bus.ovf       = ovf_q;
  assign bus.udf       = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_counter.sv
// ============================================================================
// Module : tb_pwm_counter
// Directed and randomized checks of pwm_counter against a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_counter;
  localparam int WIDTH = 16;
  localparam int PSC_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_counter_if #(.WIDTH(WIDTH), .PSC_W(PSC_W)) bus ();

  pwm_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: count value, cycles elapsed since the last advance, pulses
  int m_cnt   = 0;
  int m_wait  = 0;
  int m_ovf   = 0;
  int m_udf   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_wait = 0; m_ovf = 0; m_udf = 0;
  endfunction

  // One clock of behaviour, expressed as "advance after prescale+1 enabled cycles"
  function automatic void model_step();
    int per;
    per   = int'(bus.period);
    m_ovf = 0;
    m_udf = 0;
    if (bus.count_reset) begin
      m_cnt  = 0;
      m_wait = 0;
    end else if (!bus.en) begin
      m_wait = 0;
    end else if (m_wait >= int'(bus.prescale)) begin
      m_wait = 0;
      if (bus.upnotdown) begin
        if (m_cnt >= per) begin m_cnt = 0; m_ovf = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0)      begin m_cnt = per; m_udf = 1; end
        else if (m_cnt > per) m_cnt = per;
        else m_cnt = m_cnt - 1;
      end
    end else begin
      m_wait = m_wait + 1;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("count_val", 32'(bus.count_val), 32'(m_cnt));
    check("ovf", 32'(bus.ovf), 32'(m_ovf));
    check("udf", 32'(bus.udf), 32'(m_udf));
    check("ovf_udf_excl", 32'(bus.ovf & bus.udf), 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_counter();
    bus.count_reset = 1'b1;
    cycle();
    bus.count_reset = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_count", 32'(bus.count_val), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_udf", 32'(bus.udf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    bus.en          = 1'b1;
    bus.count_reset = 1'b0;
    bus.period      = 16'd8;
    bus.prescale    = 8'd0;
    bus.upnotdown   = 1'b1;

    // Reset held with clock running and en=1
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_count", 32'(bus.count_val), 32'd0);
    check("rst_hold_ovf", 32'(bus.ovf), 32'd0);
    check("rst_hold_udf", 32'(bus.udf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Up, period 8, prescale 0
    cycle();
    check("first_advance", 32'(bus.count_val), 32'd1);
    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      cycle();
      if (bus.ovf) pulses++;
      if (i == 7) check("up_wrap_value", 32'(bus.count_val), 32'd0);
    end
    check("up_ovf_pulses", 32'(pulses), 32'd2);

    // Prescale 2, period 3: 12-cycle ovf interval
    clear_counter();
    bus.prescale = 8'd2;
    bus.period   = 16'd3;
    pulses = 0;
    for (int i = 0; i < 36; i++) begin
      cycle();
      if (bus.ovf) pulses++;
    end
    check("psc_ovf_pulses", 32'(pulses), 32'd3);

    // Down, period 5 from 0
    bus.prescale  = 8'd0;
    clear_counter();
    bus.period    = 16'd5;
    bus.upnotdown = 1'b0;
    cycle();
    check("down_load", 32'(bus.count_val), 32'd5);
    check("down_udf", 32'(bus.udf), 32'd1);
    cycles(5);
    check("down_zero", 32'(bus.count_val), 32'd0);
    cycle();
    check("down_reload", 32'(bus.count_val), 32'd5);

    // Hold at 4, then clear with a coincident tick
    bus.upnotdown = 1'b1;
    bus.period    = 16'd8;
    clear_counter();
    cycles(4);
    check("hold_start", 32'(bus.count_val), 32'd4);
    bus.en = 1'b0;
    cycles(10);
    check("hold_value", 32'(bus.count_val), 32'd4);
    bus.en = 1'b1;
    clear_counter();
    check("clear_value", 32'(bus.count_val), 32'd0);

    // period 0, up: ovf each tick
    bus.period = 16'd0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (bus.ovf) pulses++;
    end
    check("p0_ovf_pulses", 32'(pulses), 32'd5);
    check("p0_count", 32'(bus.count_val), 32'd0);

    // period 8 -> 2 at count 6, up
    bus.period = 16'd8;
    clear_counter();
    cycles(6);
    check("shrink_pre", 32'(bus.count_val), 32'd6);
    bus.period = 16'd2;
    cycle();
    check("shrink_up_val", 32'(bus.count_val), 32'd0);
    check("shrink_up_ovf", 32'(bus.ovf), 32'd1);

    // Same change, down
    bus.period = 16'd8;
    clear_counter();
    cycles(6);
    bus.period    = 16'd2;
    bus.upnotdown = 1'b0;
    cycle();
    check("shrink_dn_val", 32'(bus.count_val), 32'd2);
    check("shrink_dn_udf", 32'(bus.udf), 32'd0);

    // Randomized live reconfiguration
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.period    = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) bus.prescale  = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) bus.upnotdown = ~bus.upnotdown;
      bus.en          = ($urandom_range(0, 9) != 0);
      bus.count_reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_counter.md
Name: pwm_counter

Overview:
- Timebase counter feeding the PWM generator stage; produces `count_val`, which `pwm_gen` compares against `period`, `compare1` and `compare2`.
- Counts up or down between 0 and `period` at a rate set by a programmable prescaler.
- Flags every wrap with a single-cycle pulse.
- Sits between the register file (configuration) and `pwm_gen` (consumer of `count_val`).

Parameters:
- WIDTH, 16, width of `count_val` and `period`.
- PSC_W, 8, width of the prescale value and the internal prescale counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; 0 holds `count_val`.
- count_reset  input  1  synchronous clear request, level-sensitive.
- period  input  WIDTH  terminal count; the sequence spans 0..period (period+1 states).
- prescale  input  PSC_W  divide ratio; the counter advances once every prescale+1 clk cycles.
- upnotdown  input  1  1 = count up, 0 = count down.
- count_val  output  WIDTH  current count, registered, drives `pwm_gen.count_val`.
- ovf  output  1  one-cycle pulse on an up-count wrap (period -> 0).
- udf  output  1  one-cycle pulse on a down-count wrap (0 -> period).

Behaviour:
- Reset (rst_n=0, asynchronous): `count_val`=0, internal `psc_cnt`=0, `ovf`=0, `udf`=0. Outputs stay at these values until the first rising clk after release.
- Priority each cycle: rst_n > count_reset > en=0 > normal counting.
- count_reset=1: `count_val`<=0, `psc_cnt`<=0, `ovf`<=0, `udf`<=0, regardless of `en`.
- en=0: `count_val` holds; `psc_cnt`<=0; `ovf`/`udf`<=0.
  - Consequence: after `en` rises, the first advance occurs prescale+1 cycles later.
- Prescaler (en=1): `tick` = (`psc_cnt` >= `prescale`).
  - On tick, `psc_cnt`<=0; otherwise `psc_cnt`<=`psc_cnt`+1.
  - prescale=0: tick every cycle.
  - The >= compare makes a reduced `prescale` take effect immediately, with no long wrap.
- Up mode (upnotdown=1), on tick:
  - If `count_val` >= `period`: `count_val`<=0 and `ovf`<=1 for one cycle.
  - Otherwise `count_val`<=`count_val`+1.
- Down mode (upnotdown=0), on tick:
  - If `count_val`==0: `count_val`<=`period` and `udf`<=1 for one cycle.
  - Else if `count_val` > `period`: `count_val`<=`period`, no pulse.
  - Otherwise `count_val`<=`count_val`-1.
- Non-tick cycles: `count_val` holds; `ovf`/`udf`<=0.
- Latency: `count_val`, `ovf` and `udf` are registered and change on the same edge as the tick. `ovf`/`udf` are high exactly while `count_val` shows its post-wrap value for that first cycle.
- period=0:
  - Up mode: `count_val` stays 0 and `ovf` pulses on every tick.
  - Down mode: `count_val` stays 0 and `udf` pulses on every tick.
- Live reconfiguration: `period`, `prescale` and `upnotdown` are sampled every cycle, with no shadowing.
  - A direction change continues from the current value.
  - A `period` reduced below `count_val` in up mode forces a wrap on the next tick.
- Arithmetic is modulo 2^WIDTH internally. The >= and == checks guarantee `count_val` never leaves 0..max(period, previous value), with no wrap through 2^WIDTH-1.
- `ovf` and `udf` are never high in the same cycle.
- Reset mid-count: takes immediate effect; no pulse is emitted.

Test Plan:
- Reset: hold rst_n=0 with en=1 and clk running, then release -> `count_val`=0, `ovf`=`udf`=0 during reset; counting begins one prescale period after release.
- Up, period=8, prescale=0, upnotdown=1: run 20 cycles -> `count_val` sequence 0,1,...,8,0,1,...; `ovf`=1 only in the cycles where `count_val` first reads 0 after 8 (two pulses, 9 cycles apart).
- Prescale=2, period=3, up: -> each value is held for exactly 3 cycles; `ovf` is high for 1 cycle every 12 cycles.
- Down, period=5, prescale=0, start from 0 -> `count_val` sequence 5,4,3,2,1,0,5; `udf` pulses on each load of 5; `ovf` stays 0.
- Hold and clear: en=0 at `count_val`=4 for 10 cycles -> value stays 4 with no pulses. en=1 with count_reset=1 for one cycle -> `count_val`=0 the next cycle; count_reset overrides a coincident tick.
- Boundaries:
  - period=0, up -> `count_val` stays 0 and `ovf` pulses every tick.
  - period changed 8->2 while `count_val`=6, up -> next tick gives 0 with `ovf`=1.
  - Same change, down -> next tick gives 2 with no `udf`.
